// File: rtl/button_pkg.sv
// Shared constants and helpers for the button response block.
// Default debounce timing is derived from clock rate and milliseconds.
package button_pkg;

   localparam int CLK_HZ      = 100000000;
   localparam int DEBOUNCE_MS = 20;

   // Auto-repeat phase: waiting for first repeat, then periodic repeats.
   typedef enum logic {
      PH_DELAY  = 1'b0,
      PH_PERIOD = 1'b1
   } rep_phase_e;

   function automatic int ms_to_cycles(input int ms, input int clk_hz);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_response_sync_chain.sv
// Multi-flop synchronizer for one asynchronous input level.
// Reset clears every stage; only the last stage is exported.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // shift the raw level through the chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/button_response.sv
// Debounced push-button to one-cycle press pulse.
// Optional auto-repeat while held: define BUTTON_RESPONSE_REPEAT_EN.
module button_response
   import button_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS, CLK_HZ),
   parameter int CNT_W           = 32,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic flag
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic             sync;
   logic             stable;
   logic             stable_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pulse_nxt;

   sync_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (btn),
      .q    (sync)
   );

   // accept a new level only after it persists for the full window
   always_comb begin
      stable_nxt = stable;
      cnt_nxt    = '0;
      if (sync != stable) begin
         if (cnt == DB_LAST) stable_nxt = sync;
         else                cnt_nxt    = cnt + ONE;
      end
   end

`ifdef BUTTON_RESPONSE_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_cnt_nxt;
   rep_phase_e       rep_phase;
   rep_phase_e       rep_phase_nxt;
   logic             rep_fire;
   logic [CNT_W-1:0] rep_last;

   assign rep_last = (rep_phase == PH_PERIOD) ? RP_LAST : RD_LAST;

   // time repeats from the initial pulse while the level stays pressed
   always_comb begin
      rep_cnt_nxt   = '0;
      rep_phase_nxt = PH_DELAY;
      rep_fire      = 1'b0;
      if (stable && stable_nxt) begin
         if (rep_cnt == rep_last) begin
            rep_fire      = 1'b1;
            rep_phase_nxt = PH_PERIOD;
         end else begin
            rep_cnt_nxt   = rep_cnt + ONE;
            rep_phase_nxt = rep_phase;
         end
      end
   end

   // repeat state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_phase <= PH_DELAY;
      end else begin
         rep_cnt   <= rep_cnt_nxt;
         rep_phase <= rep_phase_nxt;
      end
   end

   assign pulse_nxt = (stable_nxt & ~stable) | rep_fire;
`else
   assign pulse_nxt = stable_nxt & ~stable;
`endif

   // debounce state and registered press pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= 1'b0;
         cnt    <= '0;
         flag   <= 1'b0;
      end else begin
         stable <= stable_nxt;
         cnt    <= cnt_nxt;
         flag   <= pulse_nxt;
      end
   end

endmodule

// File: tb/tb_button_response.sv
// Directed bench for button_response with short debounce/repeat timing.
// Expectations follow BUTTON_RESPONSE_REPEAT_EN when it is defined.
module tb_button_response;

   logic clk;
   logic rst_n;
   logic btn;
   logic flag;

   int total = 0;
   int bad   = 0;
   int pulses;
   logic exp;

`ifdef BUTTON_RESPONSE_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   button_response #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (32),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn),
      .flag (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // advance one edge; sample point is 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // hold reset over two edges, release just after an edge with btn=b
   task automatic restart(input logic b);
      rst_n = 1'b0;
      btn   = b;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 1'b0;
      #1;
      chk("reset_flag", flag, 1'b0);
      chk("reset_stable", dut.stable, 1'b0);
      step();
      step();

      // clean press: pulse after edge 6, then held with optional repeats
      rst_n = 1'b1;
      btn   = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 57; e++) begin
         step();
         if (e == 6)
            exp = 1'b1;
         else if (REP && e >= 16 && ((e - 16) % 3) == 0)
            exp = 1'b1;
         else
            exp = 1'b0;
         pulses += int'(flag);
         chk($sformatf("clean_e%0d", e), flag, exp);
      end
      chk_int("clean_pulses", pulses, REP ? 15 : 1);

      // bounce 1,0,1,0 then hold: one pulse at edge 10
      restart(1'b0);
      pulses = 0;
      for (int e = 1; e <= 14; e++) begin
         if (e <= 4) btn = (e % 2 == 1);
         else        btn = 1'b1;
         step();
         pulses += int'(flag);
         chk($sformatf("bounce_e%0d", e), flag, e == 10);
      end
      chk_int("bounce_pulses", pulses, 1);

      // glitch of three cycles never reaches acceptance
      restart(1'b0);
      pulses = 0;
      for (int e = 1; e <= 15; e++) begin
         btn = (e <= 3);
         step();
         pulses += int'(flag);
      end
      chk_int("glitch_pulses", pulses, 0);
      chk("glitch_stable", dut.stable, 1'b0);

      // press, release for 10 cycles, press again: pulses at 6 and 22
      restart(1'b0);
      pulses = 0;
      for (int e = 1; e <= 30; e++) begin
         btn = (e <= 6) || (e >= 17);
         step();
         pulses += int'(flag);
         chk($sformatf("repress_e%0d", e), flag, (e == 6) || (e == 22));
      end
      chk_int("repress_pulses", pulses, 2);

      // async reset mid-debounce clears everything without an edge
      restart(1'b0);
      btn = 1'b1;
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_flag", flag, 1'b0);
      chk("rst_mid_stable", dut.stable, 1'b0);
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         chk($sformatf("rst_a_e%0d", e), flag, e == 6);
      end

      // async reset during the pulse cycle drops flag immediately
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_pulse_flag", flag, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 9; e++) begin
         step();
         pulses += int'(flag);
         chk($sformatf("rst_b_e%0d", e), flag, e == 6);
      end
      chk_int("rst_b_pulses", pulses, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
